// File: rtl/striping_pkg.sv
// Shared definitions for the two-lane striping scheduler: state encodings
// and the default lane word width.
package striping_pkg;

  localparam int DATA_W_DEF = 32;

  // Externally visible state codes (DRAIN is reported as RUN).
  localparam logic [1:0] ST_CODE_IDLE  = 2'd0;
  localparam logic [1:0] ST_CODE_ALIGN = 2'd1;
  localparam logic [1:0] ST_CODE_RUN   = 2'd2;
  localparam logic [1:0] ST_CODE_ERROR = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_RUN   = 3'd2,
    S_ERROR = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  function automatic logic [1:0] state_code(input state_e s);
    logic [1:0] code;
    case (s)
      S_IDLE:  code = ST_CODE_IDLE;
      S_ALIGN: code = ST_CODE_ALIGN;
      S_RUN:   code = ST_CODE_RUN;
      S_DRAIN: code = ST_CODE_RUN;
      S_ERROR: code = ST_CODE_ERROR;
      default: code = ST_CODE_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/striping_scheduler_if.sv
// Bundle of lane inputs, multiplexer-facing outputs and status for the
// striping scheduler. The slave side is the scheduler itself.
interface striping_scheduler_if
  import striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              enable;
  logic [DATA_W-1:0] in_0;
  logic              in_valid_0;
  logic [DATA_W-1:0] in_1;
  logic              in_valid_1;
  logic [DATA_W-1:0] lane_0;
  logic              valid_0;
  logic [DATA_W-1:0] lane_1;
  logic              valid_1;
  logic              full_0;
  logic              full_1;
  logic [1:0]        state;
  logic              skew_err;
  logic              ovf_err;
  logic [15:0]       word_count;

  modport master (
    output enable, in_0, in_valid_0, in_1, in_valid_1,
    input  lane_0, valid_0, lane_1, valid_1, full_0, full_1,
    input  state, skew_err, ovf_err, word_count
  );

  modport slave (
    input  enable, in_0, in_valid_0, in_1, in_valid_1,
    output lane_0, valid_0, lane_1, valid_1, full_0, full_1,
    output state, skew_err, ovf_err, word_count
  );

endinterface

// File: rtl/striping_scheduler_lane_fifo.sv
// Per-lane synchronous FIFO. Pointers carry one extra wrap bit so full and
// empty are told apart by the MSB. A push into a full FIFO is taken only
// when a pop happens in the same cycle; flush empties it immediately.
module lane_fifo
  import striping_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; flush overrides any push or pop.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/striping_scheduler.sv
// Two-lane striping scheduler: buffers each lane, aligns the lanes at
// start-up and then issues words strictly alternating lane 0 / lane 1 so
// the downstream multiplexer select never slips. Flags skew and overflow.
module striping_scheduler
  import striping_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int SKEW_MAX   = 3
) (
  input  logic                clk_2f,
  input  logic                reset,
  striping_scheduler_if.slave bus
);

  localparam int SKW = $clog2(SKEW_MAX + 2);

  state_e            st_q, st_d;
  logic              phase_q, phase_d;
  logic [SKW-1:0]    skew_cnt_q, skew_cnt_d;
  logic [DATA_W-1:0] lane_0_q, lane_0_d;
  logic [DATA_W-1:0] lane_1_q, lane_1_d;
  logic              valid_0_q, valid_0_d;
  logic              valid_1_q, valid_1_d;
  logic [15:0]       word_count_q, word_count_d;
  logic              skew_err_q, skew_err_d;
  logic              ovf_err_q, ovf_err_d;

  logic              empty_0, empty_1, full_0, full_1;
  logic              pop_0, pop_1, push_0, push_1, flush;
  logic              accept, ovf_0, ovf_1, skew_hit;
  logic [DATA_W-1:0] dout_0, dout_1;

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_0 (
    .clk   (clk_2f),
    .rst_n (reset),
    .flush (flush),
    .push  (push_0),
    .pop   (pop_0),
    .din   (bus.in_0),
    .dout  (dout_0),
    .empty (empty_0),
    .full  (full_0)
  );

  lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk   (clk_2f),
    .rst_n (reset),
    .flush (flush),
    .push  (push_1),
    .pop   (pop_1),
    .din   (bus.in_1),
    .dout  (dout_1),
    .empty (empty_1),
    .full  (full_1)
  );

  // Issue, push acceptance and next-state logic.
  always_comb begin
    st_d         = st_q;
    phase_d      = phase_q;
    skew_cnt_d   = '0;
    lane_0_d     = lane_0_q;
    lane_1_d     = lane_1_q;
    valid_0_d    = 1'b0;
    valid_1_d    = 1'b0;
    word_count_d = word_count_q;
    skew_err_d   = skew_err_q;
    ovf_err_d    = ovf_err_q;
    pop_0        = 1'b0;
    pop_1        = 1'b0;
    flush        = 1'b0;
    skew_hit     = 1'b0;

    // Only the lane selected by phase may issue; otherwise stall in place.
    if (st_q == S_RUN || st_q == S_DRAIN) begin
      if (!phase_q && !empty_0) begin
        pop_0        = 1'b1;
        lane_0_d     = dout_0;
        valid_0_d    = 1'b1;
        phase_d      = 1'b1;
        word_count_d = word_count_q + 16'd1;
      end else if (phase_q && !empty_1) begin
        pop_1        = 1'b1;
        lane_1_d     = dout_1;
        valid_1_d    = 1'b1;
        phase_d      = 1'b0;
        word_count_d = word_count_q + 16'd1;
      end
    end

    // A same-cycle pop frees the slot, so a full FIFO can still take a word.
    accept = (st_q != S_ERROR);
    push_0 = bus.in_valid_0 && accept && (!full_0 || pop_0);
    push_1 = bus.in_valid_1 && accept && (!full_1 || pop_1);
    ovf_0  = bus.in_valid_0 && accept && full_0 && !pop_0;
    ovf_1  = bus.in_valid_1 && accept && full_1 && !pop_1;

    case (st_q)
      S_IDLE: begin
        phase_d = 1'b0;
        if (bus.enable) st_d = S_ALIGN;
      end
      S_ALIGN: begin
        if (!bus.enable) begin
          flush = 1'b1;
          st_d  = S_IDLE;
        end else if (!empty_0 && !empty_1) begin
          st_d    = S_RUN;
          phase_d = 1'b0;
        end else if (empty_0 != empty_1) begin
          skew_hit = 1'b1;
        end
      end
      S_RUN: begin
        if (!bus.enable) st_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.enable) begin
          st_d = S_RUN;
        end else if (empty_0 && empty_1 && !phase_q) begin
          st_d = S_IDLE;
        end else if (phase_q ? (empty_1 && !empty_0) : (empty_0 && !empty_1)) begin
          skew_hit = 1'b1;
        end
      end
      S_ERROR: begin
        flush   = 1'b1;
        phase_d = 1'b0;
        if (!bus.enable) st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase

    // Error fires on the cycle the consecutive-skew count would pass the limit.
    if (skew_hit) begin
      if (skew_cnt_q == SKW'(SKEW_MAX)) begin
        skew_err_d = 1'b1;
        st_d       = S_ERROR;
      end else begin
        skew_cnt_d = skew_cnt_q + 1'b1;
      end
    end

    if (ovf_0 || ovf_1) begin
      ovf_err_d = 1'b1;
      st_d      = S_ERROR;
    end
  end

  // State and registered output updates.
  always_ff @(posedge clk_2f or negedge reset) begin
    if (!reset) begin
      st_q         <= S_IDLE;
      phase_q      <= 1'b0;
      skew_cnt_q   <= '0;
      lane_0_q     <= '0;
      lane_1_q     <= '0;
      valid_0_q    <= 1'b0;
      valid_1_q    <= 1'b0;
      word_count_q <= '0;
      skew_err_q   <= 1'b0;
      ovf_err_q    <= 1'b0;
    end else begin
      st_q         <= st_d;
      phase_q      <= phase_d;
      skew_cnt_q   <= skew_cnt_d;
      lane_0_q     <= lane_0_d;
      lane_1_q     <= lane_1_d;
      valid_0_q    <= valid_0_d;
      valid_1_q    <= valid_1_d;
      word_count_q <= word_count_d;
      skew_err_q   <= skew_err_d;
      ovf_err_q    <= ovf_err_d;
    end
  end

  assign bus.lane_0     = lane_0_q;
  assign bus.lane_1     = lane_1_q;
  assign bus.valid_0    = valid_0_q;
  assign bus.valid_1    = valid_1_q;
  assign bus.full_0     = full_0;
  assign bus.full_1     = full_1;
  assign bus.state      = state_code(st_q);
  assign bus.skew_err   = skew_err_q;
  assign bus.ovf_err    = ovf_err_q;
  assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_striping_scheduler.sv
// Directed bench for striping_scheduler (DATA_W=32, FIFO_DEPTH=4, SKEW_MAX=3).
module tb_striping_scheduler;
  import striping_pkg::*;

  localparam int DATA_W = 32;

  logic clk_2f = 1'b0;
  logic reset  = 1'b1;

  always #5 clk_2f = ~clk_2f;

  striping_scheduler_if #(.DATA_W(DATA_W)) bus ();

  striping_scheduler #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .SKEW_MAX   (3)
  ) dut (
    .clk_2f (clk_2f),
    .reset  (reset),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;

  // Issue monitor: alternation tracking, issued-word log and wrap observation.
  int          order_viol = 0;
  bit          exp_lane   = 1'b0;
  bit          saw_ffff   = 1'b0;
  bit          log_en     = 1'b0;
  logic [31:0] last_l1    = '0;
  logic [32:0] log_q [$];

  always @(negedge clk_2f) begin
    if (bus.valid_0 && bus.valid_1) begin
      order_viol++;
    end else if (bus.valid_0) begin
      if (exp_lane != 1'b0) order_viol++;
      exp_lane = 1'b1;
      if (log_en) log_q.push_back({1'b0, bus.lane_0});
    end else if (bus.valid_1) begin
      if (exp_lane != 1'b1) order_viol++;
      exp_lane = 1'b0;
      last_l1  = bus.lane_1;
      if (log_en) log_q.push_back({1'b1, bus.lane_1});
    end
    if (bus.word_count == 16'hFFFF) saw_ffff = 1'b1;
    if (!reset || bus.state == ST_CODE_IDLE || bus.state == ST_CODE_ERROR) exp_lane = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic drive(input logic [31:0] d0, input bit v0, input logic [31:0] d1, input bit v1);
    bus.in_0       = d0;
    bus.in_valid_0 = v0;
    bus.in_1       = d1;
    bus.in_valid_1 = v1;
  endtask

  task automatic wait_state(input logic [1:0] tgt, input int budget, input string tag);
    for (int i = 0; i < budget && bus.state != tgt; i++) tick();
    check(tag, bus.state, tgt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int vbase;
    logic [32:0] exp_e;

    bus.enable = 1'b0;
    drive('0, 1'b0, '0, 1'b0);

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_state", bus.state, ST_CODE_IDLE);
    check("rst_valids", {bus.valid_1, bus.valid_0}, 2'b00);
    check("rst_wc", bus.word_count, 16'd0);
    check("rst_full", {bus.full_1, bus.full_0}, 2'b00);
    check("rst_errs", {bus.skew_err, bus.ovf_err}, 2'b00);
    tick();
    tick();
    reset = 1'b1;

    // Basic pair: A0 then B0 on consecutive edges
    bus.enable = 1'b1;
    tick();
    check("t1_align", bus.state, ST_CODE_ALIGN);
    drive(32'hA000_0000, 1'b1, 32'hB000_0000, 1'b1);
    tick();
    drive('0, 1'b0, '0, 1'b0);
    tick();
    check("t1_run", bus.state, ST_CODE_RUN);
    check("t1_novalid", {bus.valid_1, bus.valid_0}, 2'b00);
    tick();
    check("t1_v0", {bus.valid_1, bus.valid_0}, 2'b01);
    check("t1_d0", bus.lane_0, 32'hA000_0000);
    tick();
    check("t1_v1", {bus.valid_1, bus.valid_0}, 2'b10);
    check("t1_d1", bus.lane_1, 32'hB000_0000);
    check("t1_wc", bus.word_count, 16'd2);
    tick();
    check("t1_stall", {bus.valid_1, bus.valid_0}, 2'b00);
    check("t1_state", bus.state, ST_CODE_RUN);
    bus.enable = 1'b0;
    wait_state(ST_CODE_IDLE, 8, "t1_idle");

    // Lane 1 two cycles late: aligns without error
    bus.enable = 1'b1;
    tick();
    drive(32'h1111_0000, 1'b1, '0, 1'b0);
    tick();
    drive('0, 1'b0, '0, 1'b0);
    tick();
    drive('0, 1'b0, 32'h2222_0000, 1'b1);
    tick();
    drive('0, 1'b0, '0, 1'b0);
    tick();
    check("t2_run", bus.state, ST_CODE_RUN);
    check("t2_noskew", bus.skew_err, 1'b0);
    tick();
    check("t2_v0", {bus.valid_1, bus.valid_0}, 2'b01);
    check("t2_d0", bus.lane_0, 32'h1111_0000);
    tick();
    check("t2_d1", bus.lane_1, 32'h2222_0000);
    bus.enable = 1'b0;
    wait_state(ST_CODE_IDLE, 8, "t2_idle");

    // Lane 1 five cycles late: skew error on the 4th skewed cycle
    log_en = 1'b1;
    base   = log_q.size();
    bus.enable = 1'b1;
    tick();
    drive(32'h3333_0000, 1'b1, '0, 1'b0);
    tick();
    drive('0, 1'b0, '0, 1'b0);
    tick();
    tick();
    tick();
    check("t2b_still_align", bus.state, ST_CODE_ALIGN);
    check("t2b_noskew_yet", bus.skew_err, 1'b0);
    tick();
    check("t2b_error", bus.state, ST_CODE_ERROR);
    check("t2b_skew", bus.skew_err, 1'b1);
    drive('0, 1'b0, 32'h4444_0000, 1'b1);
    tick();
    drive('0, 1'b0, '0, 1'b0);
    tick();
    check("t2b_noissue", log_q.size() - base, 0);
    bus.enable = 1'b0;
    tick();
    check("t2b_idle", bus.state, ST_CODE_IDLE);
    check("t2b_sticky", bus.skew_err, 1'b1);

    // Overflow on lane 0 while lane 1 is silent in RUN
    bus.enable = 1'b1;
    tick();
    drive(32'h5500_0000, 1'b1, 32'h6600_0000, 1'b1);
    tick();
    drive('0, 1'b0, '0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(32'h7700_0000 + i, 1'b1, '0, 1'b0);
      tick();
      if (i == 4) begin
        check("t3_full", bus.full_0, 1'b1);
        check("t3_run", bus.state, ST_CODE_RUN);
        check("t3_noovf_yet", bus.ovf_err, 1'b0);
      end
    end
    check("t3_ovf", bus.ovf_err, 1'b1);
    check("t3_error", bus.state, ST_CODE_ERROR);
    drive('0, 1'b0, '0, 1'b0);
    tick();
    check("t3_flushed", bus.full_0, 1'b0);
    bus.enable = 1'b0;
    tick();
    check("t3_idle", bus.state, ST_CODE_IDLE);
    check("t3_sticky", bus.ovf_err, 1'b1);

    // Drain: 6 words per lane with enable dropped mid-stream
    reset = 1'b0;
    #2;
    reset = 1'b1;
    check("t4_rst_errs", {bus.skew_err, bus.ovf_err}, 2'b00);
    check("t4_rst_wc", bus.word_count, 16'd0);
    bus.enable = 1'b1;
    tick();
    base  = log_q.size();
    vbase = order_viol;
    for (int i = 0; i < 6; i++) begin
      drive(32'hD000_0000 + i, 1'b1, 32'hE000_0000 + i, 1'b1);
      if (i == 3) bus.enable = 1'b0;
      tick();
      drive('0, 1'b0, '0, 1'b0);
      tick();
    end
    wait_state(ST_CODE_IDLE, 12, "t4_idle");
    check("t4_wc", bus.word_count, 16'd12);
    check("t4_count", log_q.size() - base, 12);
    for (int j = 0; j < 12 && base + j < log_q.size(); j++) begin
      exp_e = (j % 2 == 0) ? {1'b0, 32'hD000_0000 + (j / 2)} : {1'b1, 32'hE000_0000 + (j / 2)};
      check($sformatf("t4_word%0d", j), log_q[base + j], exp_e);
    end
    check("t4_order", order_viol - vbase, 0);
    log_en = 1'b0;

    // Asynchronous reset mid-RUN, then restart with fresh data
    bus.enable = 1'b1;
    tick();
    drive(32'hA500_0000, 1'b1, 32'hB500_0000, 1'b1);
    tick();
    drive(32'hC500_0000, 1'b1, 32'hD500_0000, 1'b1);
    tick();
    check("t5_run", bus.state, ST_CODE_RUN);
    drive('0, 1'b0, '0, 1'b0);
    tick();
    check("t5_pre_d0", bus.lane_0, 32'hA500_0000);
    reset = 1'b0;
    #1;
    check("t5_state", bus.state, ST_CODE_IDLE);
    check("t5_valids", {bus.valid_1, bus.valid_0}, 2'b00);
    check("t5_lane0", bus.lane_0, 32'h0);
    check("t5_wc", bus.word_count, 16'd0);
    check("t5_full", {bus.full_1, bus.full_0}, 2'b00);
    reset = 1'b1;
    tick();
    drive(32'hF000_0000, 1'b1, 32'hF000_0001, 1'b1);
    tick();
    drive('0, 1'b0, '0, 1'b0);
    tick();
    tick();
    check("t5_first_v0", {bus.valid_1, bus.valid_0}, 2'b01);
    check("t5_new_d0", bus.lane_0, 32'hF000_0000);

    // Long stream: word_count wraps past 0xFFFF, issue order unaffected
    vbase = order_viol;
    for (int n = 0; n < 32768; n++) begin
      drive(32'hA600_0000 | n, 1'b1, 32'hB600_0000 | n, 1'b1);
      tick();
      drive('0, 1'b0, '0, 1'b0);
      tick();
    end
    bus.enable = 1'b0;
    wait_state(ST_CODE_IDLE, 10, "t6_idle");
    check("t6_saw_ffff", saw_ffff, 1'b1);
    check("t6_wc_wrap", bus.word_count, 16'd2);
    check("t6_order", order_viol - vbase, 0);
    check("t6_last", last_l1, 32'hB600_7FFF);
    check("t6_errs", {bus.skew_err, bus.ovf_err}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
